ifu_prefetch: RTL

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch_pkg.sv | 14 +
 rtl/ifu_fifo.sv | 64 ++++++
 rtl/ifu_prefetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   ifu_state_e        : prefetch FSM states (BOOT, RUN, DRAIN)
//   IFU_DEPTH_DEFAULT  : default instruction-queue depth / outstanding-request limit
package ifu_prefetch_pkg;

    localparam int unsigned IFU_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction queue, DEPTH entries of WIDTH bits ({pc, instr}).
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   flush_i      : empty the queue at the next edge (overrides push/pop)
//   push_i/data_i: write data_i at the tail
//   pop_i        : drop the head entry
//   data_o       : head entry, registered storage only; zero while empty
//   full_o/empty_o: occupancy flags
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = IFU_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] fcnt_t;
    localparam fcnt_t FULL_CNT = fcnt_t'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    fcnt_t            cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head is masked while empty so a drained queue presents zeros, not stale words.
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + fcnt_t'(do_push) - fcnt_t'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues in-order word fetches on the instruction
// bus, queues responses, and handles redirects by discarding stale responses.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   redirect_i, redirect_pc_i   : flush and restart fetch at redirect_pc_i (word aligned)
//   consume_i                   : IF stage takes the head instruction
//   instr_valid_o/instr_o/instr_pc_o : head of the instruction queue
//   f_cmiss_o, f_arrival_o      : hazard-unit miss level and arrival pulse
//   imem_req_o/imem_addr_o/imem_gnt_i          : request channel
//   imem_rvalid_i/imem_rdata_i                 : in-order response channel
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = IFU_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        consume_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        f_cmiss_o,
    output logic        f_arrival_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [SW-1:0] occ_t;
    localparam occ_t DEPTH_OCC = occ_t'(DEPTH);

    ifu_state_e  state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] rpc_q, rpc_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        count_q, count_d;
    cnt_t        drop_q, drop_d;
    logic        req_q, req_d;
    logic        cmiss_q, cmiss_d;
    logic        arrival_q, arrival_d;

    logic        gnt_fire, rsp_fire, rsp_stale, enq, deq;
    logic [31:0] redir_pc;
    occ_t        occ_d;
    logic [63:0] head;
    logic        fifo_full, fifo_empty;

    assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

    always_comb begin
        gnt_fire   = req_q & imem_gnt_i;
        // A response with nothing in flight is a bus protocol error and is ignored.
        rsp_fire   = imem_rvalid_i & (inflight_q != '0);
        rsp_stale  = rsp_fire & (drop_q != '0);
        deq        = consume_i & instr_valid_o;
        enq        = rsp_fire & ~rsp_stale & (~fifo_full | deq);

        inflight_d = inflight_q + cnt_t'(gnt_fire) - cnt_t'(rsp_fire);
        fpc_d      = fpc_q + (gnt_fire ? 32'd4 : 32'd0);
        rpc_d      = rpc_q + (enq ? 32'd4 : 32'd0);
        count_d    = count_q + cnt_t'(enq) - cnt_t'(deq);
        drop_d     = drop_q - cnt_t'(rsp_stale);

        // Redirect wins over this cycle's enqueue/dequeue; every request still
        // on the bus after this edge (including one granted now) becomes stale.
        if (redirect_i) begin
            fpc_d   = redir_pc;
            rpc_d   = redir_pc;
            count_d = '0;
            drop_d  = inflight_d;
        end

        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect_i && drop_d != '0) state_d = ST_DRAIN;
            ST_DRAIN: if (!redirect_i && drop_d == '0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        // Outputs are registered from next-state values so they equal the
        // state-based definitions in the cycle they are observed.
        occ_d     = occ_t'(inflight_d) + occ_t'(count_d);
        req_d     = (state_d != ST_BOOT) && (occ_d < DEPTH_OCC);
        cmiss_d   = (state_d != ST_BOOT) && (count_d == '0);
        arrival_d = (count_q == '0) && (count_d != '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_BOOT;
            fpc_q      <= RESET_PC;
            rpc_q      <= RESET_PC;
            inflight_q <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            req_q      <= 1'b0;
            cmiss_q    <= 1'b0;
            arrival_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            cmiss_q    <= cmiss_d;
            arrival_q  <= arrival_d;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (redirect_i),
        .push_i  (enq),
        .data_i  ({rpc_q, imem_rdata_i}),
        .pop_i   (deq),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Queue occupancy and count_q move in lockstep; the FIFO flag is the source.
    assign instr_valid_o = ~fifo_empty;
    assign instr_o       = head[31:0];
    assign instr_pc_o    = head[63:32];
    assign f_cmiss_o     = cmiss_q;
    assign f_arrival_o   = arrival_q;
    assign imem_req_o    = req_q;
    assign imem_addr_o   = fpc_q;

endmodule
